// File: rtl/video_overlay_pkg.sv
// rtl/video_overlay_pkg.sv - shared record layout, types and saturating pad helpers for the box overlay
package video_overlay_pkg;

   localparam int XW = 11;
   localparam int YW = 10;

   // field offsets of one {flag,ymax,xmax,ymin,xmin} slot record, LSB first
   localparam int XMIN_LSB = 0;
   localparam int YMIN_LSB = XMIN_LSB + XW;
   localparam int XMAX_LSB = YMIN_LSB + YW;
   localparam int YMAX_LSB = XMAX_LSB + XW;
   localparam int FLAG_LSB = YMAX_LSB + YW;
   localparam int REC_W    = FLAG_LSB + 1;

   // padded coordinates are compared in a wider width so that edge+THICK never wraps
   localparam int CW = 16;

   typedef struct packed {
      logic          flag;
      logic [YW-1:0] ymax;
      logic [XW-1:0] xmax;
      logic [YW-1:0] ymin;
      logic [XW-1:0] xmin;
   } box_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic logic [CW-1:0] pad_lo(input logic [CW-1:0] v, input logic [CW-1:0] pad);
      return (v > pad) ? (v - pad) : '0;
   endfunction

   function automatic logic [CW-1:0] pad_hi(input logic [CW-1:0] v, input logic [CW-1:0] pad,
                                            input logic [CW-1:0] lim);
      return (v < lim - pad) ? (v + pad) : lim;
   endfunction

endpackage

// File: rtl/box_edge_hit.sv
// rtl/box_edge_hit.sv - combinational test of one pixel against one padded box outline
module box_edge_hit
   import video_overlay_pkg::*;
#(
   parameter int IMG_HDISP = 1280,
   parameter int IMG_VDISP = 720,
   parameter int PAD_X     = 50,
   parameter int PAD_Y     = 20,
   parameter int THICK     = 2
)(
   input  logic [XW-1:0] x_i,
   input  logic [YW-1:0] y_i,
   input  box_t          box_i,
   output logic          hit_o
);

   logic [CW-1:0] l, r, u, d, x, y, t;
   logic          valid, in_rect, on_edge;

   // padded, clamped rectangle and the pixel widened to the compare width
   always_comb begin
      l = pad_lo(CW'(box_i.xmin), CW'(PAD_X));
      r = pad_hi(CW'(box_i.xmax), CW'(PAD_X), CW'(IMG_HDISP - 1));
      u = pad_lo(CW'(box_i.ymin), CW'(PAD_Y));
      d = pad_hi(CW'(box_i.ymax), CW'(PAD_Y), CW'(IMG_VDISP - 1));
      x = CW'(x_i);
      y = CW'(y_i);
      t = CW'(THICK);
   end

   assign valid   = box_i.flag & (box_i.xmin <= box_i.xmax) & (box_i.ymin <= box_i.ymax);
   assign in_rect = (x >= l) & (x <= r) & (y >= u) & (y <= d);
   // x > r-t written as x+t > r so a narrow box near 0 cannot underflow
   assign on_edge = (x < l + t) | (x + t > r) | (y < u + t) | (y + t > d);
   assign hit_o   = valid & in_rect & on_edge;

endmodule

// File: rtl/video_multi_box_overlay.sv
// rtl/video_multi_box_overlay.sv - draws NUM_BOX padded box outlines onto an RGB888 stream, 2-cycle latency
module video_multi_box_overlay
   import video_overlay_pkg::*;
#(
   parameter int                    NUM_BOX   = 4,
   parameter int                    IMG_HDISP = 1280,
   parameter int                    IMG_VDISP = 720,
   parameter int                    PAD_X     = 50,
   parameter int                    PAD_Y     = 20,
   parameter int                    THICK     = 2,
   parameter logic [NUM_BOX*24-1:0] BOX_COLOR = {NUM_BOX{24'hFF0000}}
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     overlay_en,
   input  logic                     per_frame_vsync,
   input  logic                     per_frame_href,
   input  logic                     per_frame_clken,
   input  logic [7:0]               per_img_red,
   input  logic [7:0]               per_img_green,
   input  logic [7:0]               per_img_blue,
   input  logic [NUM_BOX*REC_W-1:0] target_pos,
   output logic                     post_frame_vsync,
   output logic                     post_frame_href,
   output logic                     post_frame_clken,
   output logic [7:0]               post_img_red,
   output logic [7:0]               post_img_green,
   output logic [7:0]               post_img_blue,
   output logic                     line_err
);

   logic                     vsync_prev_q, href_prev_q;
   logic                     vs_rise, href_fall;
   logic [XW-1:0]            x_cnt_q, x_cnt_d;
   logic [YW-1:0]            y_cnt_q, y_cnt_d;
   logic [NUM_BOX*REC_W-1:0] shadow_q, box_src;
   logic [NUM_BOX-1:0]       hit_c, hit_q;
   rgb_t                     pix1_q, out_q, out_d;
   logic                     vs1_q, hr1_q, ce1_q;
   logic                     vs2_q, hr2_q, ce2_q;
   logic                     line_err_q;

   assign vs_rise   = per_frame_vsync & ~vsync_prev_q;
   assign href_fall = ~per_frame_href & href_prev_q;
   // the pixel that coincides with the vsync rise already sees the new boxes
   assign box_src   = vs_rise ? target_pos : shadow_q;

   // coordinate of the current clken pixel; y saturates on the last line
   always_comb begin
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      if (!per_frame_vsync) begin
         x_cnt_d = '0;
         y_cnt_d = '0;
      end else if (href_fall) begin
         x_cnt_d = '0;
      end else if (per_frame_clken) begin
         if (x_cnt_q == XW'(IMG_HDISP - 1)) begin
            x_cnt_d = '0;
            if (y_cnt_q != YW'(IMG_VDISP - 1)) y_cnt_d = y_cnt_q + 1'b1;
         end else begin
            x_cnt_d = x_cnt_q + 1'b1;
         end
      end
   end

   // edge detectors, counters, per-frame shadow capture and short-line flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // prev vsync starts high so a reset inside a frame does not look like a new frame
         vsync_prev_q <= 1'b1;
         href_prev_q  <= 1'b0;
         x_cnt_q      <= '0;
         y_cnt_q      <= '0;
         shadow_q     <= '0;
         line_err_q   <= 1'b0;
      end else begin
         vsync_prev_q <= per_frame_vsync;
         href_prev_q  <= per_frame_href;
         x_cnt_q      <= x_cnt_d;
         y_cnt_q      <= y_cnt_d;
         if (vs_rise) shadow_q <= target_pos;
         line_err_q   <= href_fall & (x_cnt_q != '0);
      end
   end

   for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
      logic [REC_W-1:0] rec;
      box_t             slot_box;
      assign rec      = box_src[i*REC_W +: REC_W];
      assign slot_box = {rec[FLAG_LSB], rec[YMAX_LSB +: YW], rec[XMAX_LSB +: XW],
                         rec[YMIN_LSB +: YW], rec[XMIN_LSB +: XW]};
      box_edge_hit #(
         .IMG_HDISP (IMG_HDISP),
         .IMG_VDISP (IMG_VDISP),
         .PAD_X     (PAD_X),
         .PAD_Y     (PAD_Y),
         .THICK     (THICK)
      ) u_hit (
         .x_i   (x_cnt_q),
         .y_i   (y_cnt_q),
         .box_i (slot_box),
         .hit_o (hit_c[i])
      );
   end

   // stage 1: hit bits (only for real pixels), pixel and syncs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         pix1_q <= '0;
         vs1_q  <= 1'b0;
         hr1_q  <= 1'b0;
         ce1_q  <= 1'b0;
      end else begin
         hit_q  <= per_frame_clken ? hit_c : '0;
         pix1_q <= {per_img_red, per_img_green, per_img_blue};
         vs1_q  <= per_frame_vsync;
         hr1_q  <= per_frame_href;
         ce1_q  <= per_frame_clken;
      end
   end

   // lowest-index hitting slot wins, scanned high to low so slot 0 is applied last
   always_comb begin
      out_d = pix1_q;
      if (overlay_en) begin
         for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (hit_q[i]) out_d = BOX_COLOR[i*24 +: 24];
         end
      end
   end

   // stage 2: registered output pixel and syncs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         vs2_q <= 1'b0;
         hr2_q <= 1'b0;
         ce2_q <= 1'b0;
      end else begin
         out_q <= out_d;
         vs2_q <= vs1_q;
         hr2_q <= hr1_q;
         ce2_q <= ce1_q;
      end
   end

   assign post_frame_vsync = vs2_q;
   assign post_frame_href  = hr2_q;
   assign post_frame_clken = ce2_q;
   assign post_img_red     = out_q.r;
   assign post_img_green   = out_q.g;
   assign post_img_blue    = out_q.b;
   assign line_err         = line_err_q;

endmodule

// File: tb/tb_video_multi_box_overlay.sv
// tb/tb_video_multi_box_overlay.sv - directed self-checking bench for video_multi_box_overlay
module tb_video_multi_box_overlay;

   localparam int HD = 64;
   localparam int VD = 48;
   localparam int NB = 4;
   localparam int RW = 43;
   localparam int PW = NB * RW;
   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GREEN = 24'h00FF00;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          overlay_en = 1'b1;
   logic          vsync = 1'b0, href = 1'b0, clken = 1'b0;
   logic [7:0]    ir = '0, ig = '0, ib = '0;
   logic [PW-1:0] tpos = '0;
   logic          post_frame_vsync, post_frame_href, post_frame_clken;
   logic [7:0]    post_img_red, post_img_green, post_img_blue;
   logic          line_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [23:0] mem [HD*VD];
   int          mx = 0, my = 0;
   logic        mon_href_prev = 1'b0;
   int          red_cnt = 0, err_cnt = 0;
   int          red_base, err_base;

   video_multi_box_overlay #(
      .NUM_BOX   (NB),
      .IMG_HDISP (HD),
      .IMG_VDISP (VD),
      .PAD_X     (5),
      .PAD_Y     (3),
      .THICK     (2),
      .BOX_COLOR ({24'hFFFF00, 24'h0000FF, GREEN, RED})
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .overlay_en       (overlay_en),
      .per_frame_vsync  (vsync),
      .per_frame_href   (href),
      .per_frame_clken  (clken),
      .per_img_red      (ir),
      .per_img_green    (ig),
      .per_img_blue     (ib),
      .target_pos       (tpos),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img_red     (post_img_red),
      .post_img_green   (post_img_green),
      .post_img_blue    (post_img_blue),
      .line_err         (line_err)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pat(input int x, input int y);
      return {8'(x) ^ 8'hA5, 8'(y), 8'h3C};
   endfunction

   function automatic logic [RW-1:0] rec(input logic flag, input int ymax, input int xmax,
                                         input int ymin, input int xmin);
      return {flag, 10'(ymax), 11'(xmax), 10'(ymin), 11'(xmin)};
   endfunction

   // output-side frame capture using the bench's own coordinate count
   always @(negedge clk) begin
      if (post_frame_vsync && post_frame_href && post_frame_clken) begin
         if (mx < HD && my < VD) mem[my*HD+mx] = {post_img_red, post_img_green, post_img_blue};
         if ({post_img_red, post_img_green, post_img_blue} == RED) red_cnt++;
         if (mx == HD - 1) begin
            mx = 0;
            if (my < VD - 1) my++;
         end else mx++;
      end
      if (!post_frame_vsync) begin
         mx = 0;
         my = 0;
      end else if (mon_href_prev && !post_frame_href) mx = 0;
      mon_href_prev = post_frame_href;
      if (line_err) err_cnt++;
   end

   task automatic stream_frame(input int mid_line, input logic [PW-1:0] mid_pos, input int rst_line);
      for (int y = 0; y < VD; y++) begin
         if (y == mid_line) tpos = mid_pos;
         if (y == rst_line) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            chk_cnt++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_red,
                 post_img_green, post_img_blue, line_err} !== '0)
               $display("FAIL midframe_reset_outputs: got %h expected 0",
                        {post_img_red, post_img_green, post_img_blue});
            else pass_cnt++;
            rst = 1'b0;
            red_base = red_cnt;
         end
         vsync = 1'b1; href = 1'b0; clken = 1'b0;
         repeat (2) @(negedge clk);
         for (int x = 0; x < HD; x++) begin
            href = 1'b1; clken = 1'b1; {ir, ig, ib} = pat(x, y);
            @(negedge clk);
         end
      end
      href = 1'b0; clken = 1'b0; {ir, ig, ib} = '0;
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b0)
         $display("FAIL reset_sync: got %b expected 000", {post_frame_vsync, post_frame_href, post_frame_clken});
      else pass_cnt++;
      chk_cnt++;
      if ({post_img_red, post_img_green, post_img_blue} !== 24'h0)
         $display("FAIL reset_pixel: got %h expected 000000", {post_img_red, post_img_green, post_img_blue});
      else pass_cnt++;
      chk_cnt++;
      if (line_err !== 1'b0) $display("FAIL reset_line_err: got %b expected 0", line_err);
      else pass_cnt++;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({post_frame_clken, post_img_red, post_img_green, post_img_blue} !== 25'h0)
         $display("FAIL idle_after_reset: got %h expected 0", {post_img_red, post_img_green, post_img_blue});
      else pass_cnt++;
   endtask

   // vsync rise and first pixel in the same cycle; result appears exactly 2 cycles later
   task automatic test_latency();
      tpos = {3{43'h0}} | PW'(rec(1, 46, 62, 2, 3));
      vsync = 1'b1; href = 1'b1; clken = 1'b1; {ir, ig, ib} = pat(0, 0);
      @(negedge clk);
      chk_cnt++;
      if (post_frame_clken !== 1'b0) $display("FAIL latency_early: got clken %b expected 0", post_frame_clken);
      else pass_cnt++;
      href = 1'b0; clken = 1'b0; {ir, ig, ib} = '0;
      @(negedge clk);
      chk_cnt++;
      if ({post_img_red, post_img_green, post_img_blue} !== RED)
         $display("FAIL latency_box_color: got %h expected %h", {post_img_red, post_img_green, post_img_blue}, RED);
      else pass_cnt++;
      chk_cnt++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b111)
         $display("FAIL latency_sync: got %b expected 111", {post_frame_vsync, post_frame_href, post_frame_clken});
      else pass_cnt++;
      vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic_box();
      int px [9] = '{15, 17, 45, 16, 14, 30, 30, 44, 43};
      int py [9] = '{12, 14, 33, 20, 20, 13, 34, 25, 25};
      bit pr [9] = '{1, 0, 1, 1, 0, 1, 0, 1, 0};
      logic [23:0] exp_v;
      tpos = PW'(rec(1, 30, 40, 15, 20));
      err_base = err_cnt;
      stream_frame(-1, '0, -1);
      for (int i = 0; i < 9; i++) begin
         exp_v = pr[i] ? RED : pat(px[i], py[i]);
         chk_cnt++;
         if (mem[py[i]*HD+px[i]] !== exp_v)
            $display("FAIL basic_box (%0d,%0d): got %h expected %h", px[i], py[i], mem[py[i]*HD+px[i]], exp_v);
         else pass_cnt++;
      end
      chk_cnt++;
      if (err_cnt - err_base !== 0) $display("FAIL full_line_no_err: got %0d expected 0", err_cnt - err_base);
      else pass_cnt++;
   endtask

   task automatic test_clamp();
      tpos = PW'(rec(1, 46, 62, 2, 3));
      stream_frame(-1, '0, -1);
      for (int y = 0; y < VD; y++) begin
         chk_cnt++;
         if (mem[y*HD] !== RED) $display("FAIL clamp_col0 y=%0d: got %h expected %h", y, mem[y*HD], RED);
         else pass_cnt++;
      end
      for (int x = 0; x < HD; x++) begin
         chk_cnt++;
         if (mem[(VD-1)*HD+x] !== RED)
            $display("FAIL clamp_lastrow x=%0d: got %h expected %h", x, mem[(VD-1)*HD+x], RED);
         else pass_cnt++;
      end
      chk_cnt++;
      if (mem[20*HD+63] !== RED) $display("FAIL clamp_col63: got %h expected %h", mem[20*HD+63], RED);
      else pass_cnt++;
      chk_cnt++;
      if (mem[20*HD+61] !== pat(61, 20)) $display("FAIL clamp_inner61: got %h expected %h", mem[20*HD+61], pat(61, 20));
      else pass_cnt++;
      chk_cnt++;
      if (mem[20*HD+2] !== pat(2, 20)) $display("FAIL clamp_inner2: got %h expected %h", mem[20*HD+2], pat(2, 20));
      else pass_cnt++;
   endtask

   task automatic test_shadow_hold();
      tpos = PW'(rec(1, 30, 40, 15, 20));
      stream_frame(24, PW'(rec(1, 40, 55, 35, 50)), -1);
      chk_cnt++;
      if (mem[12*HD+15] !== RED) $display("FAIL shadow_old_top: got %h expected %h", mem[12*HD+15], RED);
      else pass_cnt++;
      chk_cnt++;
      if (mem[30*HD+15] !== RED) $display("FAIL shadow_old_after_change: got %h expected %h", mem[30*HD+15], RED);
      else pass_cnt++;
      chk_cnt++;
      if (mem[40*HD+45] !== pat(45, 40)) $display("FAIL shadow_new_early: got %h expected %h", mem[40*HD+45], pat(45, 40));
      else pass_cnt++;
      stream_frame(-1, '0, -1);
      chk_cnt++;
      if (mem[40*HD+45] !== RED) $display("FAIL shadow_new_next: got %h expected %h", mem[40*HD+45], RED);
      else pass_cnt++;
      chk_cnt++;
      if (mem[43*HD+60] !== RED) $display("FAIL shadow_new_corner: got %h expected %h", mem[43*HD+60], RED);
      else pass_cnt++;
      chk_cnt++;
      if (mem[30*HD+15] !== pat(15, 30)) $display("FAIL shadow_old_gone: got %h expected %h", mem[30*HD+15], pat(15, 30));
      else pass_cnt++;
   endtask

   task automatic test_priority();
      int px [6] = '{44, 21, 50, 20, 25, 0};
      int py [6] = '{17, 17, 25, 12, 20, 40};
      int pc [6] = '{1, 2, 2, 1, 0, 0};
      logic [23:0] exp_v;
      tpos = {rec(1, 40, 10, 42, 5), rec(1, 40, 28, 5, 30), rec(1, 35, 45, 20, 25), rec(1, 30, 40, 15, 20)};
      stream_frame(-1, '0, -1);
      for (int i = 0; i < 6; i++) begin
         exp_v = (pc[i] == 1) ? RED : (pc[i] == 2) ? GREEN : pat(px[i], py[i]);
         chk_cnt++;
         if (mem[py[i]*HD+px[i]] !== exp_v)
            $display("FAIL priority (%0d,%0d): got %h expected %h", px[i], py[i], mem[py[i]*HD+px[i]], exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_line_err();
      tpos = PW'(rec(1, 10, 12, 2, 8));
      err_base = err_cnt;
      vsync = 1'b1; href = 1'b0; clken = 1'b0;
      repeat (2) @(negedge clk);
      for (int x = 0; x < 30; x++) begin
         href = 1'b1; clken = 1'b1; {ir, ig, ib} = pat(x, 0);
         @(negedge clk);
      end
      href = 1'b0; clken = 1'b0; {ir, ig, ib} = '0;
      repeat (5) @(negedge clk);
      chk_cnt++;
      if (err_cnt - err_base !== 1) $display("FAIL line_err_pulse: got %0d cycles expected 1", err_cnt - err_base);
      else pass_cnt++;
      for (int x = 0; x < HD; x++) begin
         href = 1'b1; clken = 1'b1; {ir, ig, ib} = pat(x, 0);
         @(negedge clk);
      end
      href = 1'b0; clken = 1'b0; {ir, ig, ib} = '0;
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      chk_cnt++;
      if (err_cnt - err_base !== 1) $display("FAIL line_err_full_line: got %0d cycles expected 1", err_cnt - err_base);
      else pass_cnt++;
      chk_cnt++;
      if (mem[3] !== RED) $display("FAIL restart_x_left: got %h expected %h", mem[3], RED);
      else pass_cnt++;
      chk_cnt++;
      if (mem[2] !== pat(2, 0)) $display("FAIL restart_x_outside: got %h expected %h", mem[2], pat(2, 0));
      else pass_cnt++;
      chk_cnt++;
      if (mem[18] !== pat(18, 0)) $display("FAIL restart_x_right: got %h expected %h", mem[18], pat(18, 0));
      else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      tpos = PW'(rec(1, 30, 40, 15, 20));
      stream_frame(-1, '0, 20);
      chk_cnt++;
      if (red_cnt - red_base !== 0) $display("FAIL no_box_after_reset: got %0d red pixels expected 0", red_cnt - red_base);
      else pass_cnt++;
      stream_frame(-1, '0, -1);
      chk_cnt++;
      if (mem[12*HD+15] !== RED) $display("FAIL box_after_next_vsync: got %h expected %h", mem[12*HD+15], RED);
      else pass_cnt++;
   endtask

   task automatic test_passthrough();
      overlay_en = 1'b0;
      tpos = PW'(rec(1, 30, 40, 15, 20));
      red_base = red_cnt;
      stream_frame(-1, '0, -1);
      chk_cnt++;
      if (red_cnt - red_base !== 0) $display("FAIL disabled_red_count: got %0d expected 0", red_cnt - red_base);
      else pass_cnt++;
      chk_cnt++;
      if (mem[12*HD+15] !== pat(15, 12)) $display("FAIL disabled_edge: got %h expected %h", mem[12*HD+15], pat(15, 12));
      else pass_cnt++;
      vsync = 1'b1; href = 1'b1; clken = 1'b1; {ir, ig, ib} = 24'h123456;
      @(negedge clk);
      href = 1'b0; clken = 1'b0; {ir, ig, ib} = '0;
      @(negedge clk);
      chk_cnt++;
      if ({post_img_red, post_img_green, post_img_blue} !== 24'h123456)
         $display("FAIL disabled_latency: got %h expected 123456", {post_img_red, post_img_green, post_img_blue});
      else pass_cnt++;
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      overlay_en = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_latency();
      test_basic_box();
      test_clamp();
      test_shadow_hold();
      test_priority();
      test_line_err();
      test_reset_midframe();
      test_passthrough();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
